// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcodes, FSM state encoding and width defaults for the
//            ALU sequencer and the instruction decoder.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CTRL_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  localparam logic [3:0] OP_HOLD = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b1111;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_SUBI = 4'b1101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    READ   = 3'd4,
    RESP   = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decode
// Brief    : Combinational legal-opcode check (shared with instruction decode).
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic [CTRL_W-1:0] op,
  output logic              legal
);

  always_comb begin
    legal = 1'b0;
    case (op)
      CTRL_W'(OP_ADD), CTRL_W'(OP_SUB), CTRL_W'(OP_NOT),
      CTRL_W'(OP_AND), CTRL_W'(OP_OR), CTRL_W'(OP_XOR),
      CTRL_W'(OP_XNOR), CTRL_W'(OP_ADDI), CTRL_W'(OP_SUBI): legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Drives the shared ALU's load strobes, data bus, opcode and output
//            enable in fixed order and returns the captured result.
//            Macro ALU_SEQ_FLAGS_EN adds rsp_zero / rsp_neg outputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTRL_W-1:0] req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_neg,
`endif
  output logic [DATA_W-1:0] alu_data,
  output logic              alu_in1,
  output logic              alu_in2,
  output logic              alu_out_en,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  op_count
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [CTRL_W-1:0] r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_op_count;
  logic              w_legal;
  logic              w_accept;

  alu_op_decode #(
    .CTRL_W (CTRL_W)
  ) u_decode (
    .op    (req_op),
    .legal (w_legal)
  );

  assign w_accept = req_valid && (r_state == IDLE);

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_data    = '0;
    alu_in1     = 1'b0;
    alu_in2     = 1'b0;
    alu_out_en  = 1'b0;
    alu_control = CTRL_W'(OP_HOLD);
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_legal ? LOAD_A : RESP;
      end
      LOAD_A: begin
        alu_data = r_a;
        alu_in1  = 1'b1;
        w_next   = LOAD_B;
      end
      LOAD_B: begin
        alu_data = r_b;
        alu_in2  = 1'b1;
        w_next   = EXEC;
      end
      EXEC: begin
        alu_control = r_op;
        w_next      = READ;
      end
      READ: begin
        alu_control = r_op;
        alu_out_en  = 1'b1;
        w_next      = RESP;
      end
      RESP: begin
        // opcode returns to hold here so back-to-back identical ops still
        // present an opcode edge to the ALU
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= req_op;
        r_a        <= req_a;
        r_b        <= req_b;
        r_rsp_data <= '0;
        r_rsp_err  <= !w_legal;
      end
      if (r_state == READ) begin
        r_rsp_data <= alu_result;
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_zero;
  logic r_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_zero <= 1'b0;
        r_neg  <= 1'b0;
      end
      if (r_state == READ) begin
        r_zero <= (alu_result == '0);
        r_neg  <= alu_result[DATA_W-1];
      end
    end
  end

  assign rsp_zero = r_zero;
  assign rsp_neg  = r_neg;
`endif

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Scoreboard bench for alu_sequencer with a behavioural ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] alu_data;
  logic        alu_in1;
  logic        alu_in2;
  logic        alu_out_en;
  logic [3:0]  alu_control;
  logic [15:0] alu_result;
  logic [15:0] op_count;
`ifdef ALU_SEQ_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_neg;
`endif

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero    (rsp_zero),
    .rsp_neg     (rsp_neg),
`endif
    .alu_data    (alu_data),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out_en  (alu_out_en),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .op_count    (op_count)
  );

  // behavioural ALU: operand latches plus opcode-driven result
  logic [15:0] m_a, m_b;
  always @(posedge clk) begin
    if (alu_in1) m_a <= alu_data;
    if (alu_in2) m_b <= alu_data;
  end

  function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      4'b1111, 4'b0111: return a + b;
      4'b0001, 4'b1101: return a - b;
      4'b0010: return ~a;
      4'b0011: return a & b;
      4'b0100: return a | b;
      4'b0101: return a ^ b;
      4'b0110: return ~(a ^ b);
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_result = alu_out_en ? alu_f(alu_control, m_a, m_b) : 16'h0000;

  typedef struct {
    logic [15:0] d;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = 16'h0;
  bit          started = 1'b0;
  bit          strobe_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // invariants and response scoreboard
  always @(negedge clk) begin
    if (started) begin
      check("strobe_excl", 32'($countones({alu_in1, alu_in2, alu_out_en}) <= 1), 32'd1);
      if (!alu_in1 && !alu_in2) check("data_idle", 32'(alu_data), 32'h0);
      if (alu_in1 || alu_in2 || alu_out_en) strobe_seen = 1'b1;
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.d));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("op_count", 32'(op_count), 32'(e.cnt));
`ifdef ALU_SEQ_FLAGS_EN
          check("rsp_zero", 32'(rsp_zero), 32'((e.d == 16'h0) && !e.err));
          check("rsp_neg", 32'(rsp_neg), 32'(e.d[15] && !e.err));
`endif
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp_d, input logic exp_err, input bit push);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      if (!exp_err) exp_cnt = exp_cnt + 16'd1;
      sbq.push_back('{exp_d, exp_err, exp_cnt});
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    started = 1'b1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_ctrl", 32'({alu_in1, alu_in2, alu_out_en, alu_control}), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);

    // ADD with cycle-by-cycle strobe order
    send(4'b1111, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b1);
    @(negedge clk);
    check("c1_in1", 32'({alu_in1, alu_in2, alu_out_en}), 32'b100);
    check("c1_data", 32'(alu_data), 32'h0005);
    @(negedge clk);
    check("c2_in2", 32'({alu_in1, alu_in2, alu_out_en}), 32'b010);
    check("c2_data", 32'(alu_data), 32'h0003);
    @(negedge clk);
    check("c3_ctrl", 32'({alu_in2, alu_out_en, alu_control}), 32'h0F);
    @(negedge clk);
    check("c4_oe", 32'({alu_out_en, alu_control}), 32'h1F);
    @(negedge clk);
    check("c5_rsp_valid", 32'(rsp_valid), 32'd1);
    check("c5_ctrl_hold", 32'(alu_control), 32'h0);
    wait_drain();

    // SUB wrap
    send(4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1);
    wait_drain();

    // back-pressure
    rsp_ready = 1'b0;
    send(4'b0011, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h00F0);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_drain();

    // illegal opcodes
    strobe_seen = 1'b0;
    send(4'b0000, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    check("ill0_latency", 32'(rsp_valid), 32'd1);
    wait_drain();
    send(4'b1000, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    check("ill8_latency", 32'(rsp_valid), 32'd1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("ill_no_strobe", 32'(strobe_seen), 32'd0);
    check("ill_count", 32'(op_count), 32'(exp_cnt));

    // reset during EXEC
    send(4'b0101, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_exec_ctrl", 32'(alu_control), 32'h5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 16'h0;
    check("mid_rst_ctrl", 32'({alu_in1, alu_in2, alu_out_en, alu_control}), 32'h0);
    check("mid_rst_data", 32'(alu_data), 32'h0);
    check("mid_rst_count", 32'(op_count), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (8) @(negedge clk);
    send(4'b0101, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b1);
    wait_drain();

    // repeated ADD: opcode must pass through hold between them
    send(4'b1111, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("rep_hold", 32'({rsp_valid, alu_control}), 32'h10);
    send(4'b1111, 16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b1);
    wait_drain();

    // remaining opcodes back to back
    send(4'b0100, 16'hA000, 16'h000A, 16'hA00A, 1'b0, 1'b1);
    send(4'b0110, 16'hFF00, 16'h0F0F, 16'h0FF0, 1'b0, 1'b1);
    send(4'b0010, 16'h0000, 16'h1234, 16'hFFFF, 1'b0, 1'b1);
    send(4'b0111, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b1);
    send(4'b1101, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1);
    wait_drain();

    repeat (3) @(negedge clk);
    check("final_count", 32'(op_count), 32'(exp_cnt));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
